// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared constants and entry types for the reorder buffer
package reorder_buffer_pkg;

    localparam int RETIRE_WIDTH = 2;
    localparam int NUM_AREGS    = 32;
    localparam int AW           = $clog2(NUM_AREGS);
    localparam int NUM_WB       = 2;
    localparam int ROB_DEPTH    = 16;
    localparam int ROB_TAG_W    = $clog2(ROB_DEPTH);

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;
    // Pointer carries one extra wrap bit so full and empty are distinguishable.
    typedef logic [ROB_TAG_W:0]   rob_ptr_t;
    typedef logic [AW-1:0]        areg_t;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic        has_dst;
        areg_t       dst_index;
        logic [31:0] val;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - dispatch, writeback, flush and retire signals of the reorder buffer
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic                                disp_valid;
    logic                                disp_ready;
    logic                                disp_has_dst;
    areg_t                               disp_dst_index;
    rob_tag_t                            disp_tag;
    logic [NUM_WB-1:0]                   wb_valid;
    logic [NUM_WB-1:0][ROB_TAG_W-1:0]    wb_tag;
    logic [NUM_WB-1:0][31:0]             wb_val;
    logic                                flush;
    logic [RETIRE_WIDTH-1:0]             rob_valid;
    logic [RETIRE_WIDTH-1:0][AW-1:0]     rob_dst_index;
    logic [RETIRE_WIDTH-1:0][31:0]       rob_dst_val;
    rob_ptr_t                            rob_count;

    modport master (
        output disp_valid, disp_has_dst, disp_dst_index, wb_valid, wb_tag, wb_val, flush,
        input  disp_ready, disp_tag, rob_valid, rob_dst_index, rob_dst_val, rob_count
    );

    modport slave (
        input  disp_valid, disp_has_dst, disp_dst_index, wb_valid, wb_tag, wb_val, flush,
        output disp_ready, disp_tag, rob_valid, rob_dst_index, rob_dst_val, rob_count
    );

endinterface

// File: rtl/rob_retire_select.sv
// rtl/rob_retire_select.sv - head-window scan producing the in-order retire mask and count
module rob_retire_select
    import reorder_buffer_pkg::*;
(
    input  logic [RETIRE_WIDTH-1:0]                 win_valid,
    input  logic [RETIRE_WIDTH-1:0]                 win_done,
    output logic [RETIRE_WIDTH-1:0]                 retire,
    output logic [$clog2(RETIRE_WIDTH+1)-1:0]       n_retire
);
    localparam int NW = $clog2(RETIRE_WIDTH + 1);

    logic chain;

    // A lane may only retire when every older lane in the window retires too.
    always_comb begin
        retire   = '0;
        n_retire = '0;
        chain    = 1'b1;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            chain     = chain & win_valid[i] & win_done[i];
            retire[i] = chain;
            if (chain) begin
                n_retire = n_retire + NW'(1);
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer feeding the architectural register file
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    reorder_buffer_if.slave rob_if
);
    localparam int NW = $clog2(RETIRE_WIDTH + 1);

    rob_entry_t              entries [ROB_DEPTH];
    rob_ptr_t                head_ptr;
    rob_ptr_t                tail_ptr;
    rob_tag_t                tail_idx;
    logic                    full;
    logic                    handshake;
    rob_tag_t                lane_idx [RETIRE_WIDTH];
    logic [RETIRE_WIDTH-1:0] win_valid;
    logic [RETIRE_WIDTH-1:0] win_done;
    logic [RETIRE_WIDTH-1:0] retire;
    logic [NW-1:0]           n_retire;

    assign tail_idx          = tail_ptr[ROB_TAG_W-1:0];
    assign full              = (tail_ptr[ROB_TAG_W-1:0] == head_ptr[ROB_TAG_W-1:0]) &&
                               (tail_ptr[ROB_TAG_W] != head_ptr[ROB_TAG_W]);
    assign rob_if.disp_ready = !full && !rst;
    assign rob_if.disp_tag   = tail_idx;
    assign rob_if.rob_count  = tail_ptr - head_ptr;
    assign handshake         = rob_if.disp_valid && rob_if.disp_ready;

    // Window entries past the tail are never valid, so no count gating is needed.
    always_comb begin
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            lane_idx[i]  = head_ptr[ROB_TAG_W-1:0] + rob_tag_t'(i);
            win_valid[i] = entries[lane_idx[i]].valid;
            win_done[i]  = entries[lane_idx[i]].done;
        end
    end

    rob_retire_select u_select (
        .win_valid (win_valid),
        .win_done  (win_done),
        .retire    (retire),
        .n_retire  (n_retire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
            end
            head_ptr             <= '0;
            tail_ptr             <= '0;
            rob_if.rob_valid     <= '0;
            rob_if.rob_dst_index <= '0;
            rob_if.rob_dst_val   <= '0;
        end else if (rob_if.flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
            head_ptr         <= '0;
            tail_ptr         <= '0;
            rob_if.rob_valid <= '0;
        end else begin
            for (int i = 0; i < RETIRE_WIDTH; i++) begin
                rob_if.rob_valid[i] <= retire[i] && entries[lane_idx[i]].has_dst &&
                                       (entries[lane_idx[i]].dst_index != '0);
                if (retire[i]) begin
                    entries[lane_idx[i]].valid <= 1'b0;
                    if (entries[lane_idx[i]].has_dst && (entries[lane_idx[i]].dst_index != '0)) begin
                        rob_if.rob_dst_index[i] <= entries[lane_idx[i]].dst_index;
                        rob_if.rob_dst_val[i]   <= entries[lane_idx[i]].val;
                    end
                end
            end
            if (handshake) begin
                entries[tail_idx].valid     <= 1'b1;
                entries[tail_idx].done      <= 1'b0;
                entries[tail_idx].has_dst   <= rob_if.disp_has_dst;
                entries[tail_idx].dst_index <= rob_if.disp_dst_index;
            end
            // Later lanes are written last, so the highest lane wins a tag collision.
            for (int w = 0; w < NUM_WB; w++) begin
                if (rob_if.wb_valid[w] && entries[rob_if.wb_tag[w]].valid) begin
                    entries[rob_if.wb_tag[w]].done <= 1'b1;
                    entries[rob_if.wb_tag[w]].val  <= rob_if.wb_val[w];
                end
            end
            head_ptr <= head_ptr + rob_ptr_t'(n_retire);
            tail_ptr <= tail_ptr + rob_ptr_t'(handshake);
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - randomized scoreboard bench for reorder_buffer
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk;
    logic rst;
    reorder_buffer_if rif ();

    reorder_buffer dut (
        .clk    (clk),
        .rst    (rst),
        .rob_if (rif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        bit          has_dst;
        int          dst;
        bit          done;
        logic [31:0] val;
    } ment_t;

    typedef struct {
        int          dst;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    ment_t mq[$];
    exp_t  eq[$];
    ment_t me;
    int    m_tail = 0;
    int    cyc    = 0;
    int    n_ret;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: program-order queue; up to RETIRE_WIDTH done entries leave the front per cycle.
    always @(posedge clk) begin
        cyc++;
        if (rst || rif.flush) begin
            mq.delete();
            m_tail = 0;
        end else begin
            n_ret = 0;
            while (n_ret < RETIRE_WIDTH && n_ret < mq.size() && mq[n_ret].done) n_ret++;
            if (rif.disp_valid && mq.size() < ROB_DEPTH) begin
                me = '{tag: m_tail, has_dst: rif.disp_has_dst, dst: int'(rif.disp_dst_index),
                       done: 1'b0, val: 32'h0};
            end
            for (int i = 0; i < n_ret; i++) begin
                ment_t r;
                r = mq.pop_front();
                if (r.has_dst && r.dst != 0) eq.push_back('{dst: r.dst, val: r.val, cyc: cyc});
            end
            for (int w = 0; w < NUM_WB; w++) begin
                if (rif.wb_valid[w]) begin
                    foreach (mq[j]) begin
                        if (mq[j].tag == int'(rif.wb_tag[w])) begin
                            mq[j].done = 1'b1;
                            mq[j].val  = rif.wb_val[w];
                        end
                    end
                end
            end
            if (rif.disp_valid && (mq.size() + n_ret) < ROB_DEPTH) begin
                mq.push_back(me);
                m_tail = (m_tail + 1) % ROB_DEPTH;
            end
        end
    end

    // Monitor: compares occupancy every cycle and pops expected retires whenever rob_valid shows.
    always @(negedge clk) begin
        if (mon_en) begin
            int want;
            want = 0;
            foreach (eq[j]) if (eq[j].cyc == cyc) want++;
            check("rob_count", 64'(rif.rob_count), 64'(mq.size()));
            check("disp_ready", 64'(rif.disp_ready), 64'((mq.size() < ROB_DEPTH) && !rst));
            check("disp_tag", 64'(rif.disp_tag), 64'(m_tail));
            check("retire_lanes", 64'($countones(rif.rob_valid)), 64'(want));
            for (int i = 0; i < RETIRE_WIDTH; i++) begin
                if (rif.rob_valid[i] && eq.size() > 0 && eq[0].cyc == cyc) begin
                    exp_t e;
                    e = eq.pop_front();
                    check($sformatf("rob_dst_index[%0d]", i), 64'(rif.rob_dst_index[i]), 64'(e.dst));
                    check($sformatf("rob_dst_val[%0d]", i), 64'(rif.rob_dst_val[i]), 64'(e.val));
                end
            end
            while (eq.size() > 0 && eq[0].cyc <= cyc) void'(eq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rif.disp_valid = 1'b0;
        rif.wb_valid   = '0;
        rif.flush      = 1'b0;
    endtask

    task automatic set_disp(bit has, int dst);
        rif.disp_valid     = 1'b1;
        rif.disp_has_dst   = has;
        rif.disp_dst_index = areg_t'(dst);
    endtask

    task automatic set_wb(int lane, int tag, logic [31:0] val);
        rif.wb_valid[lane] = 1'b1;
        rif.wb_tag[lane]   = rob_tag_t'(tag % ROB_DEPTH);
        rif.wb_val[lane]   = val;
    endtask

    task automatic do_flush();
        idle();
        rif.flush = 1'b1;
        tick();
        rif.flush = 1'b0;
    endtask

    task automatic drive_random(int disp_pct, int wb_pct, int flush_pm, bit oldest);
        idle();
        rif.disp_valid     = ($urandom_range(99) < disp_pct);
        rif.disp_has_dst   = ($urandom_range(99) < 85);
        rif.disp_dst_index = areg_t'($urandom_range(NUM_AREGS - 1));
        for (int w = 0; w < NUM_WB; w++) begin
            if (mq.size() > 0 && $urandom_range(99) < wb_pct) begin
                int idx;
                idx = (oldest && w < mq.size()) ? w : int'($urandom_range(mq.size() - 1));
                set_wb(w, mq[idx].tag, $urandom);
            end else if ($urandom_range(99) < 5) begin
                set_wb(w, int'($urandom_range(ROB_DEPTH - 1)), $urandom);
            end
        end
        rif.flush = ($urandom_range(999) < flush_pm);
        tick();
    endtask

    initial begin
        int t;
        rst = 1'b1;
        idle();
        rif.disp_has_dst   = 1'b0;
        rif.disp_dst_index = '0;
        rif.wb_tag         = '0;
        rif.wb_val         = '0;
        repeat (3) tick();
        check("reset rob_valid", 64'(rif.rob_valid), 64'(0));
        check("reset rob_dst_index", 64'(rif.rob_dst_index), 64'(0));
        check("reset rob_dst_val", 64'(rif.rob_dst_val), 64'(0));
        check("reset rob_count", 64'(rif.rob_count), 64'(0));
        check("reset disp_ready", 64'(rif.disp_ready), 64'(0));
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single r5 retire.
        t = m_tail;
        set_disp(1, 5);
        tick();
        idle();
        set_wb(0, t, 32'hDEAD_BEEF);
        tick();
        idle();
        repeat (3) tick();

        // Out-of-order completion r1,r2,r3.
        t = m_tail;
        for (int i = 1; i <= 3; i++) begin
            set_disp(1, i);
            tick();
        end
        idle();
        set_wb(0, t + 2, 32'h3333_0003); tick(); idle();
        set_wb(0, t,     32'h1111_0001); tick(); idle();
        set_wb(1, t + 1, 32'h2222_0002); tick(); idle();
        repeat (4) tick();

        // Fill to full, then free two and wrap the tags.
        do_flush();
        for (int i = 0; i < ROB_DEPTH; i++) begin
            set_disp(1, (i % 31) + 1);
            tick();
        end
        tick();
        check("full rob_count", 64'(rif.rob_count), 64'(ROB_DEPTH));
        check("full disp_ready", 64'(rif.disp_ready), 64'(0));
        idle();
        set_disp(1, 9);
        set_wb(0, mq[0].tag, 32'hA0A0_0000);
        set_wb(1, mq[1].tag, 32'hA0A0_0001);
        tick();
        rif.wb_valid = '0;
        tick();
        check("full disp_ready after retire", 64'(rif.disp_ready), 64'(1));
        repeat (40) drive_random(100, 100, 0, 1'b1);

        // x0 and no-destination bundle retires silently.
        do_flush();
        set_disp(1, 0); tick();
        set_disp(0, 9); tick();
        idle();
        set_wb(0, 0, 32'h0000_00AA);
        set_wb(1, 1, 32'h0000_00BB);
        tick();
        idle();
        repeat (3) tick();

        // Both writeback lanes hit tag 3.
        do_flush();
        for (int i = 0; i < 4; i++) begin
            set_disp(1, 10 + i);
            tick();
        end
        idle();
        set_wb(0, 3, 32'h11);
        set_wb(1, 3, 32'h22);
        tick(); idle();
        set_wb(0, 0, 32'h100); set_wb(1, 1, 32'h101); tick(); idle();
        set_wb(0, 2, 32'h102); tick(); idle();
        repeat (4) tick();

        // Flush with 5 in flight plus same-cycle dispatch and writeback.
        do_flush();
        for (int i = 0; i < 5; i++) begin
            set_disp(1, 20 + i);
            tick();
        end
        idle();
        set_disp(1, 30);
        set_wb(0, 0, 32'h5555_5555);
        rif.flush = 1'b1;
        tick();
        idle();
        repeat (2) tick();
        check("flush disp_tag", 64'(rif.disp_tag), 64'(0));
        check("flush rob_count", 64'(rif.rob_count), 64'(0));

        // Random traffic, then reset mid-operation.
        repeat (60) drive_random(70, 60, 0, 1'b0);
        idle();
        rst = 1'b1;
        tick();
        check("mid reset rob_dst_index", 64'(rif.rob_dst_index), 64'(0));
        check("mid reset rob_dst_val", 64'(rif.rob_dst_val), 64'(0));
        check("mid reset rob_valid", 64'(rif.rob_valid), 64'(0));
        rst = 1'b0;
        tick();

        repeat (1500) drive_random(60, 50, 8, 1'b0);

        // Drain everything still in flight.
        for (int i = 0; i < 200 && mq.size() > 0; i++) begin
            drive_random(0, 100, 0, 1'b1);
        end
        idle();
        repeat (4) tick();
        check("drain rob_count", 64'(rif.rob_count), 64'(0));
        check("drain scoreboard empty", 64'(eq.size()), 64'(0));

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
